fpro_avalon_bridge: RTL and testbench
=====================================

Name: fpro_avalon_bridge

Overview:
Avalon-MM slave that acts as the initiator end of the FPro bus. It converts processor read/write transfers from the Platform Designer interconnect into single-cycle FPro strobes: fp_mmio_cs or fp_video_cs, fp_rd or fp_wr, fp_addr and fp_wr_data. It samples fp_rd_data and returns it with Avalon waitrequest flow control. It sits inside the fpro system, and its fp_* outputs drive the mmio and video subsystems at top level.

Parameters:
ADDR_W, 22, Avalon word-address width; bit ADDR_W-1 selects the region, lower 21 bits form fp_addr
DATA_W, 32, data width of both buses
RD_LAT, 0, extra wait cycles between the fp_rd cycle and the fp_rd_data sampling edge; legal range 0..3

Ports:
clk  input  1  system clock; FPro bus is synchronous to it
reset  input  1  asynchronous, active-high reset
avs_address  input  ADDR_W  Avalon word address
avs_read  input  1  Avalon read request
avs_write  input  1  Avalon write request
avs_writedata  input  DATA_W  Avalon write data
avs_readdata  output  DATA_W  read data, valid when avs_waitrequest=0 for a read
avs_waitrequest  output  1  low for exactly one cycle to complete the current transfer
fp_addr  output  21  FPro word address
fp_wr_data  output  DATA_W  FPro write data
fp_rd_data  input  DATA_W  FPro read data from the selected subsystem
fp_rd  output  1  one-cycle read strobe
fp_wr  output  1  one-cycle write strobe
fp_mmio_cs  output  1  mmio region select, asserted only together with a strobe
fp_video_cs  output  1  video region select, asserted only together with a strobe

Behaviour:
- States: IDLE, WR, RD, RWAIT, ACK. All outputs are registered or decoded from the state register. There are no combinational paths from avs_* to fp_*.
- Reset (asynchronous): state goes to IDLE, and a read-wait counter is cleared.
  - Output values in reset: fp_rd=fp_wr=fp_mmio_cs=fp_video_cs=0, fp_addr=0, fp_wr_data=0, avs_readdata=0, avs_waitrequest=1.
  - Reset mid-transfer aborts it. No strobe is issued after reset deasserts until a new request arrives.
- avs_waitrequest = 1 in every state except ACK.
- IDLE:
  - avs_write=1: latch address and writedata, go to WR.
  - Else avs_read=1: latch address, go to RD.
  - Both high (protocol violation): write wins and the read is dropped.
- WR (1 cycle): fp_wr=1, one cs=1, fp_addr and fp_wr_data driven from the latches. Go to ACK.
- RD (1 cycle): fp_rd=1 with one cs=1.
  - RD_LAT=0: capture fp_rd_data into avs_readdata at the end of this cycle, go to ACK.
  - RD_LAT>0: go to RWAIT.
- RWAIT: strobes and cs are 0, fp_addr is held. Count RD_LAT cycles, capture fp_rd_data at the end of the last one, go to ACK.
- ACK (1 cycle): avs_waitrequest=0, avs_readdata holds the captured value. Always go to IDLE.
  - A new request presented during ACK is not accepted. It is first seen in IDLE on the next cycle.
- Latency:
  - Write: 3 cycles from request to waitrequest low.
  - Read: 3+RD_LAT cycles.
  - Back-to-back throughput: one transfer per 3(+RD_LAT) cycles.
- Region decode:
  - Latched address bit ADDR_W-1 = 0 selects fp_mmio_cs; 1 selects fp_video_cs. Exactly one is active during a strobe, and neither outside one.
  - fp_addr = latched address [20:0]. Bits between 21 and ADDR_W-2 (when ADDR_W>22) are ignored.
- fp_addr and fp_wr_data keep their last value between transfers. avs_readdata changes only on a read capture, so writes do not disturb it.
- Addresses 0x000000 and 0x1FFFFF are passed through unchanged, with no wrap or saturation.

Test Plan:
- Reset asserted mid-RD (RD_LAT=2) -> all fp_* strobes and cs drop asynchronously, waitrequest=1; after release, no strobe until the next request.
- Write: addr=0x000010, data=0xDEADBEEF -> one-cycle fp_wr=1, fp_mmio_cs=1, fp_addr=0x000010, fp_wr_data=0xDEADBEEF in cycle 1; waitrequest=0 in cycle 2 only.
- Read with RD_LAT=0: addr=0x200005, fp_rd_data=0x12345678 during the RD cycle -> fp_video_cs=1, fp_rd=1, fp_addr=0x000005; avs_readdata=0x12345678 with waitrequest=0 in cycle 2.
- RD_LAT=2: fp_rd_data valid only 2 cycles after fp_rd -> captured correctly; waitrequest low in cycle 4, fp_rd high for exactly one cycle.
- avs_read and avs_write both high, addr=0x000003 -> only fp_wr issued, fp_rd stays 0, transfer completes in 3 cycles; avs_readdata unchanged.
- Back-to-back write then read, master re-asserting in the ACK cycle -> second fp strobe appears exactly 3 cycles after the first; cs never asserted without a strobe.

Source files
------------

// File: rtl/fpro_avalon_bridge.sv
// Avalon-MM slave driving the FPro bus: each Avalon transfer becomes one
// registered fp_rd/fp_wr strobe with a region chip-select.
//
// state | meaning
// IDLE  | waiting for avs_read/avs_write; latches address (and write data)
// WR    | fp_wr strobe with region cs
// RD    | fp_rd strobe with region cs; captures read data when RD_LAT=0
// RWAIT | counts RD_LAT cycles, captures read data on the last one
// ACK   | avs_waitrequest low for one cycle, then back to IDLE
module fpro_avalon_bridge #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [20:0]       fp_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  input  logic [DATA_W-1:0] fp_rd_data,
  output logic              fp_rd,
  output logic              fp_wr,
  output logic              fp_mmio_cs,
  output logic              fp_video_cs
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, ACK} state_t;

  // Down-counter preload: RWAIT finishes when the counter reaches zero.
  localparam logic [1:0] LAT_M1 = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A simultaneous read is dropped in favour of the write.
        if (avs_write) begin
          addr_d  = avs_address;
          wdata_d = avs_writedata;
          state_d = WR;
        end else if (avs_read) begin
          addr_d  = avs_address;
          state_d = RD;
        end
      end
      WR: state_d = ACK;
      RD: begin
        if (RD_LAT == 0) begin
          rdata_d = fp_rd_data;
          state_d = ACK;
        end else begin
          cnt_d   = LAT_M1;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = fp_rd_data;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fp_wr           = (state_q == WR);
  assign fp_rd           = (state_q == RD);
  assign strobe          = fp_wr | fp_rd;
  assign fp_mmio_cs      = strobe & ~addr_q[ADDR_W-1];
  assign fp_video_cs     = strobe &  addr_q[ADDR_W-1];
  assign fp_addr         = addr_q[20:0];
  assign fp_wr_data      = wdata_q;
  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = (state_q != ACK);

endmodule

// File: tb/tb_fpro_avalon_bridge.sv
// Bench for fpro_avalon_bridge: one instance with RD_LAT=0, one with RD_LAT=2,
// each with its own FPro slave responder and Avalon request lines.
module tb_fpro_avalon_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [21:0] avs_address;
  logic [31:0] avs_writedata;
  logic [1:0]  avs_read, avs_write;
  logic [1:0]  avs_waitrequest, fp_rd, fp_wr, fp_mmio_cs, fp_video_cs;
  logic [31:0] avs_readdata [2];
  logic [31:0] fp_wr_data   [2];
  logic [31:0] fp_rd_data   [2];
  logic [20:0] fp_addr      [2];

  fpro_avalon_bridge #(.ADDR_W(22), .DATA_W(32), .RD_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read[0]), .avs_write(avs_write[0]),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata[0]),
    .avs_waitrequest(avs_waitrequest[0]), .fp_addr(fp_addr[0]),
    .fp_wr_data(fp_wr_data[0]), .fp_rd_data(fp_rd_data[0]), .fp_rd(fp_rd[0]),
    .fp_wr(fp_wr[0]), .fp_mmio_cs(fp_mmio_cs[0]), .fp_video_cs(fp_video_cs[0])
  );

  fpro_avalon_bridge #(.ADDR_W(22), .DATA_W(32), .RD_LAT(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read[1]), .avs_write(avs_write[1]),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata[1]),
    .avs_waitrequest(avs_waitrequest[1]), .fp_addr(fp_addr[1]),
    .fp_wr_data(fp_wr_data[1]), .fp_rd_data(fp_rd_data[1]), .fp_rd(fp_rd[1]),
    .fp_wr(fp_wr[1]), .fp_mmio_cs(fp_mmio_cs[1]), .fp_video_cs(fp_video_cs[1])
  );

  // Slave data is a fixed function of {region, address}; outside the valid
  // cycle the responder drives the complement so a mistimed capture is visible.
  function automatic logic [31:0] slave_val(input logic [21:0] key);
    return {10'h2AB, key};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  logic [1:0]  pv;
  logic [21:0] pk0, pk1;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {pv[0], fp_rd[1]};
    pk0 <= {fp_video_cs[1], fp_addr[1]};
    pk1 <= pk0;
  end

  always_comb begin
    fp_rd_data[0] = fp_rd[0] ? slave_val({fp_video_cs[0], fp_addr[0]})
                             : ~slave_val({fp_video_cs[0], fp_addr[0]});
    fp_rd_data[1] = pv[1] ? slave_val(pk1) : ~slave_val({fp_video_cs[1], fp_addr[1]});
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model_rd [2];
  int          last_strobe_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One Avalon transfer; expectations come from the transaction-level model.
  task automatic xfer(input int d, input bit wr, input bit rd, input logic [21:0] addr,
                      input logic [31:0] data, input bit b2b, input bit keep,
                      input bit exp_video, input logic [20:0] exp_fpaddr, input int exp_ack);
    int          n_wr, n_rd, s_rel, ack_rel, base, gap;
    bit          cs_err, wr_eff, rd_eff;
    logic        s_video;
    logic [20:0] s_addr;
    logic [31:0] s_wd, rdv, exp_rd;
    n_wr = 0; n_rd = 0; s_rel = -1; ack_rel = -1; gap = -1; cs_err = 0;
    s_video = 1'bx; s_addr = 'x; s_wd = 'x; rdv = 'x;
    wr_eff = wr;
    rd_eff = rd & ~wr;
    base = b2b ? 1 : 0;
    avs_address = addr;
    avs_writedata = data;
    avs_write[d] = wr;
    avs_read[d] = rd;
    for (int c = 1; c <= 12 && ack_rel < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (fp_wr[d] | fp_rd[d]) begin
        n_wr += int'(fp_wr[d]);
        n_rd += int'(fp_rd[d]);
        s_rel = c;
        s_video = fp_video_cs[d];
        s_addr = fp_addr[d];
        s_wd = fp_wr_data[d];
        if (fp_mmio_cs[d] == fp_video_cs[d]) cs_err = 1;
        gap = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
      end else if (fp_mmio_cs[d] | fp_video_cs[d]) begin
        cs_err = 1;
      end
      if (!avs_waitrequest[d]) begin
        ack_rel = c;
        rdv = avs_readdata[d];
      end
    end
    if (!keep) begin
      avs_read[d] = 1'b0;
      avs_write[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    exp_rd = rd_eff ? slave_val({exp_video, exp_fpaddr}) : model_rd[d];
    chk("ack_cycle", 64'(ack_rel), 64'(exp_ack + base));
    chk("wr_strobes", 64'(n_wr), 64'(wr_eff));
    chk("rd_strobes", 64'(n_rd), 64'(rd_eff));
    chk("strobe_cycle", 64'(s_rel), 64'(1 + base));
    chk("cs_exclusive", 64'(cs_err), 64'd0);
    chk("region_cs", 64'(s_video), 64'(exp_video));
    chk("fp_addr", 64'(s_addr), 64'(exp_fpaddr));
    if (wr_eff) chk("fp_wr_data", 64'(s_wd), 64'(data));
    chk("readdata", 64'(rdv), 64'(exp_rd));
    if (b2b) chk("b2b_strobe_gap", 64'(gap), 64'd3);
    model_rd[d] = exp_rd;
  endtask

  typedef struct {
    int          dut;
    bit          wr;
    bit          rd;
    logic [21:0] addr;
    logic [31:0] data;
    bit          exp_video;
    logic [20:0] exp_fpaddr;
    int          exp_ack;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{0, 1, 0, 22'h000010, 32'hDEADBEEF, 0, 21'h000010, 2};
    vecs[1] = '{0, 0, 1, 22'h200005, 32'h0,        1, 21'h000005, 2};
    vecs[2] = '{1, 0, 1, 22'h200005, 32'h0,        1, 21'h000005, 4};
    vecs[3] = '{0, 1, 1, 22'h000003, 32'hCAFEF00D, 0, 21'h000003, 2};
    vecs[4] = '{0, 1, 0, 22'h000000, 32'h00000000, 0, 21'h000000, 2};
    vecs[5] = '{0, 0, 1, 22'h1FFFFF, 32'h0,        0, 21'h1FFFFF, 2};
    vecs[6] = '{1, 1, 0, 22'h3FFFFF, 32'h00000001, 1, 21'h1FFFFF, 2};
    vecs[7] = '{1, 0, 1, 22'h000000, 32'h0,        0, 21'h000000, 4};

    reset = 1'b1;
    avs_read = '0;
    avs_write = '0;
    avs_address = '0;
    avs_writedata = '0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_waitrequest", 64'(avs_waitrequest[d]), 64'd1);
      chk("rst_strobes_cs", 64'({fp_rd[d], fp_wr[d], fp_mmio_cs[d], fp_video_cs[d]}), 64'd0);
      chk("rst_fp_addr", 64'(fp_addr[d]), 64'd0);
      chk("rst_fp_wr_data", 64'(fp_wr_data[d]), 64'd0);
      chk("rst_readdata", 64'(avs_readdata[d]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, 0, 0,
           vecs[i].exp_video, vecs[i].exp_fpaddr, vecs[i].exp_ack);

    // Back-to-back: the master re-asserts a new request during the ACK cycle.
    xfer(0, 1, 0, 22'h000020, 32'h0BADF00D, 0, 1, 0, 21'h000020, 2);
    xfer(0, 0, 1, 22'h200021, 32'h0, 1, 0, 1, 21'h000021, 2);

    // Reset asserted in the middle of the RD cycle of the RD_LAT=2 instance.
    avs_address = 22'h200077;
    avs_read[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rd_strobe_seen", 64'(fp_rd[1]), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_strobes_cs", 64'({fp_rd[1], fp_wr[1], fp_mmio_cs[1], fp_video_cs[1]}), 64'd0);
    chk("rst_mid_waitrequest", 64'(avs_waitrequest[1]), 64'd1);
    chk("rst_mid_fp_addr", 64'(fp_addr[1]), 64'd0);
    avs_read = '0;
    avs_write = '0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(negedge clk);
    reset = 1'b0;
    begin
      int spurious;
      spurious = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (fp_rd[1] | fp_wr[1] | fp_mmio_cs[1] | fp_video_cs[1] | ~avs_waitrequest[1]) spurious++;
      end
      chk("rst_no_strobe_after", 64'(spurious), 64'd0);
    end

    // Randomized transfers checked against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int          d, kind;
      bit          wr, rd;
      logic [21:0] addr;
      logic [31:0] data;
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      wr = (kind != 1);
      rd = (kind != 0);
      addr = 22'($urandom);
      data = $urandom;
      xfer(d, wr, rd, addr, data, 0, 0, addr[21], addr[20:0],
           2 + ((rd && !wr) ? lat_of(d) : 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
